// File: rtl/eu_max_reduce.sv
// Streaming max/min/argmax reduction over LANES-wide beats for the softmax path.
// Result is registered and held until consumed; a new vector may open in the same cycle.
module eu_max_reduce #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int IDX_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          signed_mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_max,
    output logic [DATA_WIDTH-1:0]         out_min,
    output logic [IDX_WIDTH-1:0]          out_idx,
    output logic                          out_ovf
);

    localparam int DW = DATA_WIDTH;
    localparam int IW = IDX_WIDTH;
    localparam logic [IW:0] STEP = (IW+1)'(LANES);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0] acc_max_q, acc_max_d;
    logic [DW-1:0] acc_min_q, acc_min_d;
    logic [IW-1:0] acc_idx_q, acc_idx_d;
    logic [IW-1:0] base_q, base_d;
    logic          mode_q, mode_d;
    logic          wrap_q, wrap_d;
    logic          vovf_q, vovf_d;

    logic [DW-1:0] max_q, max_d;
    logic [DW-1:0] min_q, min_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          ovf_q, ovf_d;

    logic          take;
    logic          first;
    logic          cur_mode;
    logic [IW-1:0] cur_base;
    logic [DW-1:0] b_max, b_min, lane;
    logic [IW-1:0] b_lane, b_idx;
    logic [IW-1:0] base_nxt;
    logic          carry;

    function automatic logic gt(input logic [DW-1:0] a,
                                input logic [DW-1:0] b,
                                input logic          sgn);
        if (sgn) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    assign out_valid = (state_q == HOLD);
    assign in_ready  = rst_n && (!out_valid || out_ready);
    assign take      = in_valid && in_ready;
    assign first     = (state_q != ACC);
    assign out_max   = max_q;
    assign out_min   = min_q;
    assign out_idx   = idx_q;
    assign out_ovf   = ovf_q;

    // Lane reduction; strict compare keeps the lowest lane on max ties.
    always_comb begin
        cur_mode = first ? signed_mode : mode_q;
        cur_base = first ? '0 : base_q;
        b_max    = in_data[0 +: DW];
        b_min    = in_data[0 +: DW];
        b_lane   = '0;
        lane     = '0;
        for (int k = 1; k < LANES; k++) begin
            lane = in_data[k*DW +: DW];
            if (gt(lane, b_max, cur_mode)) begin
                b_max  = lane;
                b_lane = IW'(k);
            end
            if (gt(b_min, lane, cur_mode)) begin
                b_min = lane;
            end
        end
        b_idx = cur_base + b_lane;
        {carry, base_nxt} = {1'b0, cur_base} + STEP;
    end

    always_comb begin
        acc_max_d = acc_max_q;
        acc_min_d = acc_min_q;
        acc_idx_d = acc_idx_q;
        base_d    = base_q;
        mode_d    = mode_q;
        wrap_d    = wrap_q;
        vovf_d    = vovf_q;
        max_d     = max_q;
        min_d     = min_q;
        idx_d     = idx_q;
        ovf_d     = ovf_q;
        if (take) begin
            base_d = base_nxt;
            if (first) begin
                acc_max_d = b_max;
                acc_min_d = b_min;
                acc_idx_d = b_idx;
                mode_d    = signed_mode;
                wrap_d    = carry;
                vovf_d    = 1'b0;
                ovf_d     = 1'b0;
            end else begin
                if (gt(b_max, acc_max_q, mode_q)) begin
                    acc_max_d = b_max;
                    acc_idx_d = b_idx;
                end
                if (gt(acc_min_q, b_min, mode_q)) begin
                    acc_min_d = b_min;
                end
                // A beat arriving after the counter wrapped means overflow.
                wrap_d = wrap_q | carry;
                vovf_d = vovf_q | wrap_q;
            end
            if (in_last) begin
                max_d = acc_max_d;
                min_d = acc_min_d;
                idx_d = acc_idx_d;
                ovf_d = vovf_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (take) state_d = in_last ? HOLD : ACC;
            end
            ACC: begin
                if (take && in_last) state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    if (take) state_d = in_last ? HOLD : ACC;
                    else      state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_max_q <= '0;
            acc_min_q <= '0;
            acc_idx_q <= '0;
            base_q    <= '0;
            mode_q    <= 1'b0;
            wrap_q    <= 1'b0;
            vovf_q    <= 1'b0;
            max_q     <= '0;
            min_q     <= '0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_max_q <= acc_max_d;
            acc_min_q <= acc_min_d;
            acc_idx_q <= acc_idx_d;
            base_q    <= base_d;
            mode_q    <= mode_d;
            wrap_q    <= wrap_d;
            vovf_q    <= vovf_d;
            max_q     <= max_d;
            min_q     <= min_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_eu_max_reduce.sv
// Directed and random checks of eu_max_reduce against a plain-arithmetic model.
// A second instance with IDX_WIDTH=3 shares the stimulus to exercise index overflow.
module tb_eu_max_reduce;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        signed_mode;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_max;
    logic [7:0]  out_min;
    logic [7:0]  out_idx;
    logic        out_ovf;

    logic        rdy_b;
    logic        ov_b;
    logic [7:0]  max_b;
    logic [7:0]  min_b;
    logic [2:0]  idx_b;
    logic        ovf_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    eu_max_reduce u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .signed_mode(signed_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_max    (out_max),
        .out_min    (out_min),
        .out_idx    (out_idx),
        .out_ovf    (out_ovf)
    );

    eu_max_reduce #(.IDX_WIDTH(3)) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .signed_mode(signed_mode),
        .in_valid   (in_valid),
        .in_ready   (rdy_b),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (ov_b),
        .out_ready  (out_ready),
        .out_max    (max_b),
        .out_min    (min_b),
        .out_idx    (idx_b),
        .out_ovf    (ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int a, input int b,
                                         input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    // Reference: flatten to element values, scan with strict > / <.
    function automatic void model(input logic [31:0] bq[$], input bit sm,
                                  output int mx, output int mn,
                                  output int ai, output int n);
        logic [7:0] e;
        int v;
        n = 0; mx = 0; mn = 0; ai = 0;
        foreach (bq[b]) begin
            for (int k = 0; k < 4; k++) begin
                e = bq[b][8*k +: 8];
                v = sm ? int'($signed(e)) : int'(e);
                if (n == 0 || v > mx) begin
                    mx = v;
                    ai = n;
                end
                if (n == 0 || v < mn) mn = v;
                n++;
            end
        end
    endfunction

    task automatic send_beat(input logic [31:0] d, input bit last,
                             input bit sm);
        int w;
        @(negedge clk);
        in_valid    = 1'b1;
        in_data     = d;
        in_last     = last;
        signed_mode = sm;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
    endtask

    task automatic run_vec(input logic [31:0] bq[$], input bit sm,
                           input bit mix_sm);
        int mx, mn, ai, n;
        bit s;
        for (int i = 0; i < bq.size(); i++) begin
            s = (i == 0 || !mix_sm) ? sm : bit'($urandom_range(0, 1));
            send_beat(bq[i], i == bq.size() - 1, s);
        end
        chk("latency", 32'(out_valid), 32'd1);
        chk("latency_b", 32'(ov_b), 32'd1);
        model(bq, sm, mx, mn, ai, n);
        chk("max", 32'(out_max), 32'(mx[7:0]));
        chk("min", 32'(out_min), 32'(mn[7:0]));
        chk("idx", 32'(out_idx), 32'(ai % 256));
        chk("ovf", 32'(out_ovf), 32'(n > 256));
        chk("max_b", 32'(max_b), 32'(mx[7:0]));
        chk("idx_b", 32'(idx_b), 32'(ai % 8));
        chk("ovf_b", 32'(ovf_b), 32'(n > 8));
        consume();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] q[$];
        int nb;
        rst_n       = 1'b0;
        signed_mode = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        out_ready   = 1'b0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_max", 32'(out_max), 32'd0);
        chk("rst_min", 32'(out_min), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        q = {pack(12, 6, 1, -3), pack(5, -3, 7, 0)};
        run_vec(q, 1'b1, 1'b0);
        chk("t1_max", 32'(out_max), 32'h0C);
        chk("t1_min", 32'(out_min), 32'hFD);
        chk("t1_idx", 32'(out_idx), 32'd0);

        q = {pack(8'h80, 8'h7F, 1, 0)};
        run_vec(q, 1'b1, 1'b0);
        chk("sgn_max", 32'(out_max), 32'h7F);
        chk("sgn_idx", 32'(out_idx), 32'd1);
        chk("sgn_min", 32'(out_min), 32'h80);
        run_vec(q, 1'b0, 1'b0);
        chk("uns_max", 32'(out_max), 32'h80);
        chk("uns_idx", 32'(out_idx), 32'd0);
        chk("uns_min", 32'(out_min), 32'h00);

        q = {pack(3, 9, 9, 2), pack(9, 1, 1, 1)};
        run_vec(q, 1'b0, 1'b0);
        chk("tie_idx", 32'(out_idx), 32'd1);

        send_beat(pack(10, 20, 30, 40), 1'b1, 1'b0);
        chk("bp_lat", 32'(out_valid), 32'd1);
        @(negedge clk);
        in_valid    = 1'b1;
        in_data     = pack(5, 1, 2, 3);
        in_last     = 1'b1;
        signed_mode = 1'b1;
        repeat (5) begin
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_max", 32'(out_max), 32'd40);
            chk("bp_idx", 32'(out_idx), 32'd3);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_rel", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        chk("nb_valid", 32'(out_valid), 32'd1);
        chk("nb_max", 32'(out_max), 32'd5);
        chk("nb_min", 32'(out_min), 32'd1);
        chk("nb_idx", 32'(out_idx), 32'd0);
        consume();
        chk("keep_max", 32'(out_max), 32'd5);

        send_beat(pack(50, 0, 0, 0), 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_ready", 32'(in_ready), 32'd0);
        chk("mr_max", 32'(out_max), 32'd0);
        chk("mr_min", 32'(out_min), 32'd0);
        chk("mr_idx", 32'(out_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mr_no_result", 32'(out_valid), 32'd0);
        end
        q = {pack(1, 2, 3, 4), pack(8, 0, 0, 0)};
        run_vec(q, 1'b0, 1'b0);
        chk("mr2_max", 32'(out_max), 32'd8);
        chk("mr2_idx", 32'(out_idx), 32'd4);

        q = {pack(1, 2, 3, 4), pack(5, 6, 7, 0), pack(0, 99, 3, 2)};
        run_vec(q, 1'b1, 1'b0);
        chk("ov_ovf_b", 32'(ovf_b), 32'd1);
        chk("ov_idx_b", 32'(idx_b), 32'd1);
        chk("ov_max_b", 32'(max_b), 32'd99);
        chk("ov_idx_a", 32'(out_idx), 32'd9);
        chk("ov_ovf_a", 32'(out_ovf), 32'd0);

        for (int v = 0; v < 30; v++) begin
            q  = {};
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) q.push_back($urandom);
            run_vec(q, bit'($urandom_range(0, 1)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/eu_max_reduce.md
Name: eu_max_reduce

Overview:
- Streaming signed/unsigned max/min reduction unit for the Softmax datapath.
- Accepts a vector as a sequence of LANES-wide beats and returns the vector's maximum, minimum and argmax index once the last beat is taken.
- Feeds the max-subtraction stage ahead of the exponent unit.
- Generalises the two-operand compare/swap cell to N lanes, arbitrary vector length, a signedness mode and a valid/ready handshake.

Parameters:
- DATA_WIDTH, 8, element width in bits.
- LANES, 4, elements per input beat; power of two, at least 1.
- IDX_WIDTH, 8, element-index width; maximum vector length is 2^IDX_WIDTH elements.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned compare; sampled on the first beat of each vector.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  LANES*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]; lane 0 is the lowest element index.
- in_last  in  1  marks the final beat of a vector.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_max  out  DATA_WIDTH  vector maximum.
- out_min  out  DATA_WIDTH  vector minimum.
- out_idx  out  IDX_WIDTH  element index of the maximum.
- out_ovf  out  1  vector exceeded 2^IDX_WIDTH elements; index wrapped.

Behaviour:
- Reset (async, rst_n low): all outputs 0, in_ready 0 while rst_n low; state IDLE, accumulators and beat counter cleared. Reset mid-vector discards the partial vector; no result is produced for it.
- States:
  - IDLE: no vector open; in_ready = !out_valid || out_ready.
  - ACC: vector open; same in_ready rule.
  - HOLD: result pending, vector closed.
- Transitions:
  - IDLE to ACC: first beat accepted with in_last = 0.
  - IDLE to HOLD: first beat accepted with in_last = 1 (single-beat vector).
  - ACC to HOLD: beat accepted with in_last = 1.
  - HOLD to IDLE: out_ready with no beat accepted.
  - HOLD to ACC / HOLD: on out_ready, a new first beat may be accepted in the same cycle (in_last = 0 or 1 respectively); no bubble.
- Per beat: combinational lane reduction, then compare with the accumulator.
  - Max ties resolve to the lowest element index (strict greater-than to replace).
  - The element index of a lane is beat_cnt*LANES + lane, taken modulo 2^IDX_WIDTH.
- First beat: initialises the accumulators from that beat alone; prior contents are ignored. signed_mode is latched there and held for the rest of the vector; changes mid-vector are ignored.
- Latency: out_valid rises the cycle after the in_last beat is accepted. out_max, out_min, out_idx and out_ovf are registered and stable while out_valid && !out_ready.
- Backpressure: out_valid && !out_ready deasserts in_ready; no beat is lost or accepted.
- Overflow: out_ovf = 1 when the beat counter wraps before in_last is seen. out_max and out_min remain exact; out_idx is modulo. out_ovf clears with the next first beat.
- in_valid low mid-vector: accumulators hold; there is no timeout.
- Output registers keep the last result after consumption; only out_valid drops.

Test Plan:
- LANES=4, signed: beats {12,6,1,-3} then {5,-3,7,0} with last -> out_max=12, out_min=-3, out_idx=0, out_valid one cycle after the last beat.
- Signed vs unsigned, single beat {0x80,0x7F,0x01,0x00}: signed_mode=1 -> max 0x7F idx 1, min 0x80; signed_mode=0 -> max 0x80 idx 0, min 0x00.
- Tie: beats {3,9,9,2},{9,1,1,1} last -> out_idx=1.
- Backpressure: out_ready=0 for 5 cycles after the result -> in_ready=0, outputs stable. Then out_ready=1 with a new first beat in the same cycle -> both handshakes complete, no bubble.
- Reset mid-vector: rst_n pulsed low after 1 of 3 beats -> outputs 0, no result. A fresh 2-beat vector {1,2,3,4},{8,0,0,0} -> max 8 idx 4.
- IDX_WIDTH=3, LANES=4, 3 beats with max in beat 2 lane 1 -> out_ovf=1, out_idx=1 (9 mod 8), out_max exact.
